uart_tx_engine: RTL and testbench
=================================

UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning data bits per frame; legal range 5..8.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning transmit buffer entries; power of two, at least 2.
REQ-003 SHALL have parameter DIV_WIDTH, default 16, meaning width of the baud divisor.
REQ-004 SHALL have port pclk, input, 1 bit: the only clock; all state changes on the rising edge.
REQ-005 SHALL have port areset, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port baud_div, input, DIV_WIDTH bits: pclk cycles per bit period.
REQ-007 SHALL have port parity_en, input, 1 bit: a parity bit is appended when high.
REQ-008 SHALL have port parity_odd, input, 1 bit: 1 selects odd parity, 0 selects even parity.
REQ-009 SHALL have port stop_two, input, 1 bit: 1 selects two stop bits, 0 selects one.
REQ-010 SHALL have port tx_data, input, DATA_WIDTH bits: the word to send.
REQ-011 SHALL have port tx_valid, input, 1 bit: tx_data is valid.
REQ-012 SHALL have port tx_ready, output, 1 bit: the buffer can accept a word.
REQ-013 SHALL have port tx, output, 1 bit: serial line; idle level is high.
REQ-014 SHALL have port bclk, output, 1 bit: one-pclk-cycle pulse at every bit-period boundary.
REQ-015 SHALL have port busy, output, 1 bit: high whenever the state machine is not IDLE.
REQ-016 SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1 bits: number of buffered words.

Function
REQ-017 SHALL accept a word on each rising edge where tx_valid and tx_ready are both high; tx_ready = (fifo_level != FIFO_DEPTH).
REQ-018 SHALL hold the buffer as a circular FIFO whose read and write pointers wrap modulo FIFO_DEPTH.
REQ-019 SHALL leave fifo_level unchanged when a push and a pop occur on the same edge.
REQ-020 SHALL ignore tx_valid when the buffer is full, with no overwrite and no level change.
REQ-021 SHALL implement states IDLE, START, DATA, PARITY, STOP1 and STOP2; each non-IDLE state lasts exactly one bit period, except DATA, which lasts DATA_WIDTH bit periods.
REQ-022 SHALL, in IDLE with fifo_level > 0: pop one word, latch parity_en, parity_odd, stop_two and baud_div, clear the baud counter, and enter START.
REQ-023 SHALL drive tx low in START; drive the data LSB first in DATA; drive parity in PARITY; drive tx high in STOP1 and STOP2.
REQ-024 SHALL compute even parity as the XOR of all data bits, and odd parity as its inverse.
REQ-025 SHALL sequence DATA -> PARITY when latched parity_en = 1, otherwise DATA -> STOP1.
REQ-026 SHALL sequence STOP1 -> STOP2 when latched stop_two = 1.
REQ-027 SHALL, at the end of the final stop bit, go to START with a fresh pop and no idle gap if fifo_level > 0, else go to IDLE.
REQ-028 SHALL use a baud counter that counts 0..baud_div-1 while busy, with a bit-period boundary at count = baud_div-1; baud_div = 0 SHALL be treated as 1.
REQ-029 SHALL never let input configuration changes during a frame affect that frame; only the latched values are used.
REQ-030 SHALL place the START bit on tx on the second rising edge after the accepting edge, when the buffer was empty and the state was IDLE.
REQ-031 SHALL make the frame duration exactly (2 + DATA_WIDTH + parity_en + stop_two) × max(baud_div,1) pclk cycles.
REQ-032 SHALL register tx and bclk, with no combinational path from inputs to either.

Reset
REQ-033 SHALL, while areset = 0, asynchronously force: tx = 1, bclk = 0, busy = 0, tx_ready = 1, fifo_level = 0, state = IDLE, pointers = 0, baud counter = 0.
REQ-034 SHALL, on a reset asserted mid-frame, drop the frame and the buffered words, and return tx high immediately without waiting for a clock edge.
REQ-035 SHALL resume normal operation on the first rising edge after areset deasserts.

Verification
REQ-036 baud_div = 4, DATA_WIDTH = 8, no parity, one stop bit, send 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; busy lasts 40 cycles; 10 bclk pulses.
REQ-037 parity_en = 1, send 0x07: even -> parity bit 1; odd -> parity bit 0; stop_two = 1 -> frame lasts 12 bit periods.
REQ-038 FIFO_DEPTH = 4, 5 consecutive valid words while the first frame is in flight -> tx_ready low at fifo_level = 4; all 5 frames sent back-to-back with no high gap beyond the stop bits.
REQ-039 baud_div = 0 -> one bit per pclk cycle; 8N1 frame lasts 10 cycles.
REQ-040 areset pulsed during the DATA state -> tx = 1 and fifo_level = 0 at once; the next word is sent cleanly after release.
REQ-041 Change parity_en and baud_div during a frame -> the current frame is unchanged; the next frame uses the new settings.

Source files
------------

// File: rtl/uart_tx_engine.sv
// UART transmit engine: FIFO-buffered words, serialised as start/data/parity/stop.
// Frame settings are captured per word so a mid-frame config change never tears a frame.
module uart_tx_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          pclk,
  input  logic                          areset,
  input  logic [DIV_WIDTH-1:0]          baud_div,
  input  logic                          parity_en,
  input  logic                          parity_odd,
  input  logic                          stop_two,
  input  logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          bclk,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [BW-1:0] LAST = BW'(DATA_WIDTH-1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP1, STOP2
  } state_t;

  state_t state, state_nx;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wptr, rptr;
  logic                  push, pop;

  logic [DIV_WIDTH-1:0]  cnt, div_l;
  logic [BW-1:0]         bit_idx;
  logic [DATA_WIDTH-1:0] data_l;
  logic                  par_en_l, stop2_l, par_bit;
  logic                  tick, more;
  logic                  tx_d, bclk_d;

  assign tx_ready = (fifo_level != FULL);
  assign push     = tx_valid & tx_ready;
  assign busy     = (state != IDLE);
  assign tick     = (cnt == div_l - 1'b1);
  assign more     = (fifo_level != '0);

  always_ff @(posedge pclk) begin
    if (push) mem[wptr] <= tx_data;
  end

  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: ;
      endcase
    end
  end

  // Per-frame snapshot; a zero divisor is stored as 1
  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      data_l   <= '0;
      par_en_l <= 1'b0;
      stop2_l  <= 1'b0;
      par_bit  <= 1'b0;
      div_l    <= DIV_WIDTH'(1);
    end else if (pop) begin
      data_l   <= mem[rptr];
      par_en_l <= parity_en;
      stop2_l  <= stop_two;
      par_bit  <= (^mem[rptr]) ^ parity_odd;
      div_l    <= (baud_div == '0) ? DIV_WIDTH'(1) : baud_div;
    end
  end

  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      cnt     <= '0;
      bit_idx <= '0;
    end else if (pop) begin
      cnt     <= '0;
      bit_idx <= '0;
    end else if (state != IDLE) begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick && state == DATA) bit_idx <= bit_idx + 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (more) state_nx = START;
      START:  if (tick) state_nx = DATA;
      DATA:
        if (tick && bit_idx == LAST)
          state_nx = par_en_l ? PARITY : STOP1;
      PARITY: if (tick) state_nx = STOP1;
      STOP1:
        if (tick) begin
          if (stop2_l)   state_nx = STOP2;
          else if (more) state_nx = START;
          else           state_nx = IDLE;
        end
      STOP2:
        if (tick) state_nx = more ? START : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // tx follows the state one cycle later, so it is purely registered
  always_comb begin
    pop    = (state_nx == START) && (state != START);
    bclk_d = (state != IDLE) && tick;
    tx_d   = 1'b1;
    unique case (state)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_l[bit_idx];
      PARITY:  tx_d = par_bit;
      STOP1:   tx_d = 1'b1;
      STOP2:   tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      tx   <= 1'b1;
      bclk <= 1'b0;
    end else begin
      tx   <= tx_d;
      bclk <= bclk_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: directed steps, line decoder checks
// every frame against a scoreboard of expected words/configs.
module tb_uart_tx_engine;

  logic        pclk = 1'b0;
  logic        areset;
  logic [15:0] baud_div;
  logic        parity_en, parity_odd, stop_two;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready, tx, bclk, busy;
  logic [2:0]  fifo_level;

  typedef struct {
    logic [7:0] data;
    bit         pe;
    bit         po;
    bit         s2;
    int         div;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int frames_done = 0;
  int n_exp = 0;
  int b2b = 0;

  uart_tx_engine dut (
    .pclk       (pclk),
    .areset     (areset),
    .baud_div   (baud_div),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .stop_two   (stop_two),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx         (tx),
    .bclk       (bclk),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] d);
    exp_t e;
    for (int i = 0; i < 500 && !tx_ready; i++) @(negedge pclk);
    tx_data  = d;
    tx_valid = 1'b1;
    e.data = d;
    e.pe   = parity_en;
    e.po   = parity_odd;
    e.s2   = stop_two;
    e.div  = int'(baud_div);
    sb.push_back(e);
    n_exp++;
    @(negedge pclk);
    tx_valid = 1'b0;
  endtask

  task automatic measure(output int bc, output int nb, output logic tx1);
    bc = 0;
    nb = 0;
    tx1 = 1'bx;
    for (int i = 0; i < 400; i++) begin
      if (i == 1) tx1 = tx;
      if (bclk) nb++;
      if (!busy) break;
      bc++;
      @(negedge pclk);
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000; i++) begin
      if (frames_done == n_exp && !busy && sb.size() == 0) break;
      @(negedge pclk);
    end
    chk("frames_done", frames_done, n_exp);
    chk("queue_empty", sb.size(), 0);
  endtask

  // One isolated frame: push, then time busy and bclk from the pop edge
  task automatic single(input logic [7:0] d, input int eb, input int ep,
                        input string tag);
    int bc, nb;
    logic tx1;
    push_word(d);
    @(negedge pclk);
    measure(bc, nb, tx1);
    chk({tag, "_busy"}, bc, eb);
    chk({tag, "_bclk"}, nb, ep);
    wait_done();
  endtask

  // Line decoder: samples half a cycle into every bit period
  initial begin : mon
    exp_t e;
    int d, nbits;
    bit chained, abort;
    logic eb;
    chained = 1'b0;
    forever begin
      if (!chained) begin
        @(negedge pclk);
        if (!(areset && tx === 1'b0)) continue;
      end
      chained = 1'b0;
      if (sb.size() == 0) begin
        chk("unexpected_frame", 1, 0);
        for (int j = 0; j < 1000 && tx !== 1'b1; j++) @(negedge pclk);
        continue;
      end
      e = sb.pop_front();
      d = (e.div == 0) ? 1 : e.div;
      nbits = 10 + int'(e.pe) + int'(e.s2);
      abort = 1'b0;
      for (int i = 0; i < nbits; i++) begin
        if (i > 0) repeat (d) @(negedge pclk);
        if (!areset) begin
          abort = 1'b1;
          break;
        end
        if (i == 0)                 eb = 1'b0;
        else if (i <= 8)            eb = e.data[i-1];
        else if (e.pe && i == 9)    eb = (^e.data) ^ e.po;
        else                        eb = 1'b1;
        chk($sformatf("bit%0d_of_%0h", i, e.data), tx, eb);
      end
      if (abort) continue;
      frames_done++;
      repeat (d) @(negedge pclk);
      if (areset && tx === 1'b0) begin
        b2b++;
        chained = 1'b1;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int bc, nb, b0;
    logic tx1;
    areset     = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = '0;
    baud_div   = 16'd4;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    stop_two   = 1'b0;
    repeat (3) @(negedge pclk);
    chk("rst_tx", tx, 1);
    chk("rst_bclk", bclk, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", tx_ready, 1);
    chk("rst_level", fifo_level, 0);
    areset = 1'b1;
    @(negedge pclk);

    // 8N1, divisor 4, 0xA5 with start-latency check
    push_word(8'hA5);
    chk("acc_level", fifo_level, 1);
    chk("acc_busy", busy, 0);
    chk("acc_tx", tx, 1);
    @(negedge pclk);
    chk("pop_level", fifo_level, 0);
    chk("pop_tx", tx, 1);
    measure(bc, nb, tx1);
    chk("start_latency_tx", tx1, 0);
    chk("a5_busy", bc, 40);
    chk("a5_bclk", nb, 10);
    wait_done();

    // parity even / odd, then two stop bits
    parity_en = 1'b1;
    single(8'h07, 44, 11, "even");
    parity_odd = 1'b1;
    stop_two   = 1'b1;
    single(8'h07, 48, 12, "odd_2stop");
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    stop_two   = 1'b0;

    // divisor 0 acts as 1
    baud_div = 16'd0;
    single(8'h3C, 10, 10, "div0");

    // fill the FIFO behind an in-flight frame
    baud_div = 16'd2;
    b0 = b2b;
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    push_word(8'h44);
    push_word(8'h55);
    chk("full_level", fifo_level, 4);
    chk("full_ready", tx_ready, 0);
    tx_data  = 8'hEE;
    tx_valid = 1'b1;
    repeat (3) @(negedge pclk);
    tx_valid = 1'b0;
    chk("full_hold_level", fifo_level, 4);
    chk("full_hold_ready", tx_ready, 0);
    wait_done();
    chk("back_to_back", b2b - b0, 4);

    // reset pulsed while in DATA
    baud_div = 16'd4;
    push_word(8'h00);
    push_word(8'h33);
    repeat (8) @(negedge pclk);
    chk("pre_rst_tx", tx, 0);
    chk("pre_rst_level", fifo_level, 1);
    @(posedge pclk);
    #2 areset = 1'b0;
    #1;
    chk("arst_tx", tx, 1);
    chk("arst_level", fifo_level, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", tx_ready, 1);
    chk("arst_bclk", bclk, 0);
    sb.delete();
    n_exp = n_exp - 2;
    repeat (10) @(negedge pclk);
    areset = 1'b1;
    @(negedge pclk);
    single(8'h96, 40, 10, "post_rst");

    // config change mid-frame only affects the next frame
    b0 = b2b;
    push_word(8'h81);
    @(negedge pclk);
    chk("cfg_busy", busy, 1);
    parity_en  = 1'b1;
    parity_odd = 1'b1;
    baud_div   = 16'd2;
    push_word(8'h42);
    measure(bc, nb, tx1);
    chk("cfg_busy_total", bc + 1, 62);
    chk("cfg_bclk_total", nb, 21);
    wait_done();
    chk("cfg_b2b", b2b - b0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
